// File: rtl/query_loader_pkg.sv
// Shared types and constants for the query_loader front end.
package query_loader_pkg;

   // Loader FSM states
   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, WAIT} state_t;

   // Default frame start marker
   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFFFF_FFFF;

   // Width of the top-k count handed to the search core
   localparam int K_WIDTH = 16;

   // Payload words following the sync word: DIM query words, k, vertex id
   function automatic int FRAME_WORDS(input int dim);
      return dim + 2;
   endfunction

endpackage

// File: rtl/query_loader_if.sv
// Host/core side signal bundle of query_loader.
// slave  : the loader itself (consumes host words, drives the request).
// master : the environment (host stream source and search core).
interface query_loader_if
   import query_loader_pkg::*;
#(
   parameter int DIM = 4
);
   logic [31:0]          data_in;
   logic                 data_valid_in;
   logic                 done_in;
   logic [DIM-1:0][31:0] query_out;
   logic [K_WIDTH-1:0]   k_out;
   logic [31:0]          vertex_id_out;
   logic                 valid_out;
   logic                 busy_out;
   logic                 frame_err_out;
   logic [31:0]          cycles_out;

   modport slave (
      input  data_in, data_valid_in, done_in,
      output query_out, k_out, vertex_id_out, valid_out, busy_out,
             frame_err_out, cycles_out
   );

   modport master (
      output data_in, data_valid_in, done_in,
      input  query_out, k_out, vertex_id_out, valid_out, busy_out,
             frame_err_out, cycles_out
   );
endinterface

// File: rtl/query_loader_latency_counter.sv
// Saturating 32-bit search latency counter. The count freezes whenever
// enable drops (the loader drops it once done has been seen).
module latency_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        enable,
   output logic [31:0] count
);

   // Clear, count while enabled, hold at all-ones instead of wrapping
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/query_loader.sv
// query_loader: deserialises a host word stream (SYNC, q[0..DIM-1], k, vid)
// into one search request for the bfis core, issues it as a one-cycle
// valid pulse and holds off further requests until the core reports done.
// Optional feature macro: QUERY_LOADER_CYCLE_COUNT_EN enables the search
// latency counter behind cycles_out; without it cycles_out is tied to 0.
module query_loader
   import query_loader_pkg::*;
#(
   parameter int          DIM       = 4,
   parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD
)
(
   input  logic          clk_in,
   input  logic          rst_in,
   query_loader_if.slave bus
);

   localparam int FRAME = FRAME_WORDS(DIM);
   localparam int IDX_W = $clog2(FRAME);
   localparam logic [IDX_W-1:0] K_IDX   = IDX_W'(DIM);
   localparam logic [IDX_W-1:0] VID_IDX = IDX_W'(DIM + 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [31:0]      staging [FRAME];
   logic             sync_seen;

   assign sync_seen = bus.data_valid_in && (bus.data_in == SYNC_WORD);

   // Loader FSM. The request outputs are loaded on the edge that enters
   // ISSUE so they are already valid during the valid_out cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state             <= IDLE;
         idx               <= '0;
         bus.query_out     <= '0;
         bus.k_out         <= '0;
         bus.vertex_id_out <= '0;
         bus.valid_out     <= 1'b0;
         bus.busy_out      <= 1'b0;
         bus.frame_err_out <= 1'b0;
         for (int i = 0; i < FRAME; i++) begin
            staging[i] <= '0;
         end
      end else begin
         bus.valid_out     <= 1'b0;
         bus.frame_err_out <= 1'b0;
         case (state)
            IDLE: begin
               if (sync_seen) begin
                  state <= LOAD;
                  idx   <= '0;
               end
            end
            LOAD: begin
               if (sync_seen) begin
                  // Resync: abandon the partial frame and start over
                  bus.frame_err_out <= 1'b1;
                  idx               <= '0;
               end else if (bus.data_valid_in) begin
                  if ((idx == K_IDX) && (bus.data_in[K_WIDTH-1:0] == '0)) begin
                     // A zero top-k is meaningless to the core: drop the frame
                     bus.frame_err_out <= 1'b1;
                     state             <= IDLE;
                     idx               <= '0;
                  end else begin
                     staging[idx] <= bus.data_in;
                     if (idx == VID_IDX) begin
                        for (int i = 0; i < DIM; i++) begin
                           bus.query_out[i] <= staging[i];
                        end
                        bus.k_out         <= staging[K_IDX][K_WIDTH-1:0];
                        bus.vertex_id_out <= bus.data_in;
                        bus.valid_out     <= 1'b1;
                        bus.busy_out      <= 1'b1;
                        state             <= ISSUE;
                        idx               <= '0;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               // Host words, sync included, are ignored while the core runs
               if (bus.done_in) begin
                  state        <= IDLE;
                  bus.busy_out <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef QUERY_LOADER_CYCLE_COUNT_EN
   logic        cnt_clear;
   logic        cnt_enable;
   logic [31:0] cnt_value;

   // Counter restarts during the valid_out cycle and runs for every WAIT
   // cycle, including the one in which done is sampled.
   assign cnt_clear  = (state == ISSUE);
   assign cnt_enable = (state == WAIT);

   latency_counter u_latency_counter (
      .clk    (clk_in),
      .rst    (rst_in),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .count  (cnt_value)
   );

   assign bus.cycles_out = cnt_value;
`else
   assign bus.cycles_out = '0;
`endif

endmodule

// File: doc/query_loader.md
# query_loader

Front-end stage feeding the `bfis` search core. It deserialises a 32-bit host word stream into one search request: a DIM-element query vector, a top-k count and an entry vertex id. It issues the request to `bfis` as a single-cycle valid pulse, then holds off new requests until the core reports completion. It also measures search latency in clock cycles for host readback.

## Interface
Parameters:
- DIM, 4, query vector length (words)
- SYNC_WORD, 32'hFFFF_FFFF, frame start marker

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- data_in  input  32  host word
- data_valid_in  input  1  data_in valid this cycle
- done_in  input  1  search core finished (sampled only in WAIT)
- query_out  output  32 x [DIM]  query vector to core
- k_out  output  16  top-k count to core
- vertex_id_out  output  32  entry vertex id to core
- valid_out  output  1  one-cycle request strobe to core
- busy_out  output  1  high in ISSUE and WAIT
- frame_err_out  output  1  one-cycle protocol-error pulse
- cycles_out  output  32  latency of last or current search

## Operation
- Frame: SYNC_WORD, q[0]..q[DIM-1], k, vid. That is DIM+2 payload words after sync. Only cycles with data_valid_in high are counted.
- FSM states: IDLE, LOAD, ISSUE, WAIT.
  - IDLE: valid SYNC_WORD -> LOAD with idx=0. Other words are dropped.
  - LOAD: a valid payload word is written to staging[idx] and idx increments. Once the vid word (idx=DIM+1) is accepted -> ISSUE.
  - LOAD, valid SYNC_WORD: pulse frame_err_out, restart at idx=0, stay in LOAD.
  - LOAD, k word with low 16 bits == 0: pulse frame_err_out, go to IDLE, frame discarded.
  - ISSUE (one cycle): copy staging into query_out, k_out (low 16 bits of the k word) and vertex_id_out. Assert valid_out. Clear latency counter. Go to WAIT.
  - WAIT: increment latency counter each cycle. When done_in is seen -> IDLE with the counter frozen. All input words, including SYNC_WORD, are dropped.
- Outputs query_out, k_out and vertex_id_out change only in ISSUE. They stay stable until the next ISSUE.
- A payload word equal to SYNC_WORD cannot be sent; this is a protocol limitation.
- Latency counter saturates at 32'hFFFF_FFFF.

## Timing
- Reset (any state, including mid-frame or WAIT):
  - FSM goes to IDLE and idx=0.
  - All outputs are 0, including query_out, k_out, vertex_id_out, cycles_out, valid_out and frame_err_out.
  - Staging registers are cleared.
- valid_out rises in the cycle after the clock edge that accepts the vid word. The pipeline cost is one cycle.
- busy_out is registered. It is high in the same cycle as valid_out and stays high through WAIT.
- cycles_out = number of edges from valid_out to the edge that samples done_in.
  - Example: done_in high in the cycle immediately after valid_out gives cycles_out = 1.
- done_in is ignored in IDLE, LOAD and ISSUE.
- frame_err_out pulses in the cycle after the offending word is sampled.
- Back-to-back frames: a SYNC_WORD is recognised in the cycle after WAIT exits. Earlier sync words are lost.

## Configuration
- QUERY_LOADER_CYCLE_COUNT_EN
  - Defined: latency counter and cycles_out behave as described above.
  - Undefined: no counter flops; cycles_out is constant 0. The FSM, including WAIT and done_in handling, is unchanged.

## Structure
- Package `query_loader_pkg`:
  - state enum (IDLE, LOAD, ISSUE, WAIT)
  - default SYNC_WORD
  - FRAME_WORDS(DIM) = DIM+2 as a function
  - K_WIDTH = 16
- One sub-module, `latency_counter`:
  - clear and enable inputs, freeze on done
  - 32-bit saturating count
  - instantiated only under QUERY_LOADER_CYCLE_COUNT_EN

## Test plan
- Nominal frame: stream FFFFFFFF,5,7,1,1,4,1 with DIM=4 -> one valid_out pulse with query_out={5,7,1,1}, k_out=4, vertex_id_out=1. busy_out is high from that cycle.
- Latency: raise done_in 37 cycles after valid_out -> cycles_out=37, busy_out low next cycle. A new frame is then accepted.
- Gapped input: same frame with data_valid_in low for 3 cycles between each word -> identical outputs, valid_out only after vid.
- Sync mid-frame: FFFFFFFF,5,7,FFFFFFFF,9,9,9,9,2,3 -> frame_err_out pulses once, then query_out={9,9,9,9}, k_out=2, vertex_id_out=3.
- k=0: FFFFFFFF,1,2,3,4,0,1 -> frame_err_out pulse, no valid_out, outputs keep previous values.
- Reset in WAIT: assert rst_in 10 cycles after valid_out -> all outputs 0, FSM in IDLE. A new frame completes normally.
